// File: rtl/mouse_pkg.sv
// +------------------------------------------------------------------+
// | mouse_pkg : shared PS/2 mouse types, status-byte and error bits  |
// | Revision  : 1.0                                                  |
// +------------------------------------------------------------------+
`default_nettype none

package mouse_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_B0 = 2'd0,
    ST_WAIT_B1 = 2'd1,
    ST_WAIT_B2 = 2'd2,
    ST_UPDATE  = 2'd3
  } state_e;

  localparam int unsigned BIT_LEFT   = 0;
  localparam int unsigned BIT_RIGHT  = 1;
  localparam int unsigned BIT_MIDDLE = 2;
  localparam int unsigned BIT_SYNC   = 3;
  localparam int unsigned BIT_XSIGN  = 4;
  localparam int unsigned BIT_YSIGN  = 5;
  localparam int unsigned BIT_XOVF   = 6;
  localparam int unsigned BIT_YOVF   = 7;

  localparam int unsigned ERR_PARITY = 0;
  localparam int unsigned ERR_STOP   = 1;

  // Sync bit is only used for framing, so it is not kept once the byte is accepted.
  typedef struct packed {
    logic       y_ovf;
    logic       x_ovf;
    logic       y_sign;
    logic       x_sign;
    logic [2:0] buttons;
  } status_t;

  function automatic status_t decode_status(input logic [7:0] b);
    status_t s;
    s.y_ovf   = b[BIT_YOVF];
    s.x_ovf   = b[BIT_XOVF];
    s.y_sign  = b[BIT_YSIGN];
    s.x_sign  = b[BIT_XSIGN];
    s.buttons = {b[BIT_MIDDLE], b[BIT_RIGHT], b[BIT_LEFT]};
    return s;
  endfunction

  function automatic logic byte_ok(input logic [1:0] err);
    return !err[ERR_PARITY] && !err[ERR_STOP];
  endfunction

endpackage

`default_nettype wire

// File: rtl/mouse_axis_accum.sv
// +------------------------------------------------------------------+
// | mouse_axis_accum : one clamped cursor axis, resets to MAX/2      |
// | Revision         : 1.0                                           |
// +------------------------------------------------------------------+
`default_nettype none

module mouse_axis_accum #(
  parameter int MAX    = 160,
  parameter int POS_W  = 8,
  parameter bit NEGATE = 1'b0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             upd,
  input  logic [8:0]       delta,
  input  logic             ovf,
  output logic [POS_W-1:0] pos
);

  localparam logic [POS_W-1:0] RST_POS = POS_W'(MAX / 2);
  localparam logic [POS_W-1:0] TOP_POS = POS_W'(MAX - 1);
  localparam logic signed [10:0] TOP_S = 11'(MAX - 1);

  logic [POS_W-1:0]   pos_q, pos_d;
  logic signed [10:0] term;
  logic signed [10:0] step;
  logic signed [10:0] sum;

  // An overflowed report carries meaningless magnitude, so it moves nothing.
  assign term = ovf ? 11'sd0 : 11'(signed'(delta));

  generate
    if (NEGATE) begin : g_neg
      assign step = -term;
    end else begin : g_pos
      assign step = term;
    end
  endgenerate

  always_comb begin
    pos_d = pos_q;
    sum   = signed'(11'(pos_q)) + step;
    if (upd) begin
      if (sum < 11'sd0) begin
        pos_d = '0;
      end else if (sum > TOP_S) begin
        pos_d = TOP_POS;
      end else begin
        pos_d = sum[POS_W-1:0];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pos_q <= RST_POS;
    end else begin
      pos_q <= pos_d;
    end
  end

  assign pos = pos_q;

endmodule

`default_nettype wire

// File: rtl/mouse_packet_decoder.sv
// +------------------------------------------------------------------+
// | mouse_packet_decoder : 3-byte PS/2 stream packet framing/decode  |
// | Revision             : 1.0                                       |
// +------------------------------------------------------------------+
`default_nettype none

module mouse_packet_decoder
  import mouse_pkg::*;
#(
  parameter int MAX_X   = 160,
  parameter int MAX_Y   = 120,
  parameter int POS_W   = 8,
  parameter int TIMEOUT = 200000
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             ENABLE,
  input  logic             BYTE_READY,
  input  logic [7:0]       BYTE_READ,
  input  logic [1:0]       BYTE_ERROR_CODE,
  output logic [POS_W-1:0] X_POS,
  output logic [POS_W-1:0] Y_POS,
  output logic [2:0]       BUTTONS,
  output logic [8:0]       DX,
  output logic [8:0]       DY,
  output logic             PACKET_VALID,
  output logic             PACKET_ERROR
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  status_t          status_q, status_d;
  logic [7:0]       xbyte_q, xbyte_d;
  logic [7:0]       ybyte_q, ybyte_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       buttons_q, buttons_d;
  logic [8:0]       dx_q, dx_d;
  logic [8:0]       dy_q, dy_d;
  logic             pkt_valid_q, pkt_valid_d;
  logic             pkt_error_q, pkt_error_d;
  logic             good;
  logic             do_update;
  logic [8:0]       dx_raw;
  logic [8:0]       dy_raw;

  assign good      = byte_ok(BYTE_ERROR_CODE);
  assign dx_raw    = {status_q.x_sign, xbyte_q};
  assign dy_raw    = {status_q.y_sign, ybyte_q};
  assign do_update = ENABLE && (state_q == ST_UPDATE);

  always_comb begin
    state_d     = state_q;
    status_d    = status_q;
    xbyte_d     = xbyte_q;
    ybyte_d     = ybyte_q;
    cnt_d       = cnt_q;
    buttons_d   = buttons_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    pkt_valid_d = 1'b0;
    pkt_error_d = 1'b0;

    if (!ENABLE) begin
      state_d  = ST_WAIT_B0;
      status_d = '0;
      xbyte_d  = '0;
      ybyte_d  = '0;
      cnt_d    = '0;
    end else begin
      case (state_q)
        ST_WAIT_B0: begin
          cnt_d = '0;
          if (BYTE_READY) begin
            if (good && BYTE_READ[BIT_SYNC]) begin
              status_d = decode_status(BYTE_READ);
              state_d  = ST_WAIT_B1;
            end else begin
              pkt_error_d = 1'b1;
            end
          end
        end
        ST_WAIT_B1, ST_WAIT_B2: begin
          // A byte arriving on the expiry cycle takes priority over the timeout.
          if (BYTE_READY) begin
            cnt_d = '0;
            if (!good) begin
              pkt_error_d = 1'b1;
              state_d     = ST_WAIT_B0;
            end else if (state_q == ST_WAIT_B1) begin
              xbyte_d = BYTE_READ;
              state_d = ST_WAIT_B2;
            end else begin
              ybyte_d = BYTE_READ;
              state_d = ST_UPDATE;
            end
          end else if (cnt_q == CNT_LAST) begin
            cnt_d       = '0;
            pkt_error_d = 1'b1;
            state_d     = ST_WAIT_B0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_UPDATE: begin
          cnt_d       = '0;
          state_d     = ST_WAIT_B0;
          pkt_valid_d = 1'b1;
          buttons_d   = status_q.buttons;
          dx_d        = dx_raw;
          dy_d        = dy_raw;
        end
        default: state_d = ST_WAIT_B0;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_WAIT_B0;
      status_q    <= '0;
      xbyte_q     <= '0;
      ybyte_q     <= '0;
      cnt_q       <= '0;
      buttons_q   <= '0;
      dx_q        <= '0;
      dy_q        <= '0;
      pkt_valid_q <= 1'b0;
      pkt_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      status_q    <= status_d;
      xbyte_q     <= xbyte_d;
      ybyte_q     <= ybyte_d;
      cnt_q       <= cnt_d;
      buttons_q   <= buttons_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      pkt_valid_q <= pkt_valid_d;
      pkt_error_q <= pkt_error_d;
    end
  end

  mouse_axis_accum #(
    .MAX    (MAX_X),
    .POS_W  (POS_W),
    .NEGATE (1'b0)
  ) u_x_axis (
    .CLK   (CLK),
    .RESET (RESET),
    .upd   (do_update),
    .delta (dx_raw),
    .ovf   (status_q.x_ovf),
    .pos   (X_POS)
  );

  // PS/2 reports +Y as up; the screen axis grows downward.
  mouse_axis_accum #(
    .MAX    (MAX_Y),
    .POS_W  (POS_W),
    .NEGATE (1'b1)
  ) u_y_axis (
    .CLK   (CLK),
    .RESET (RESET),
    .upd   (do_update),
    .delta (dy_raw),
    .ovf   (status_q.y_ovf),
    .pos   (Y_POS)
  );

  assign BUTTONS      = buttons_q;
  assign DX           = dx_q;
  assign DY           = dy_q;
  assign PACKET_VALID = pkt_valid_q;
  assign PACKET_ERROR = pkt_error_q;

endmodule

`default_nettype wire

// File: tb/tb_mouse_packet_decoder.sv
// +------------------------------------------------------------------+
// | tb_mouse_packet_decoder : directed bench for the packet decoder  |
// | Revision                : 1.0                                    |
// +------------------------------------------------------------------+
`default_nettype none

module tb_mouse_packet_decoder;

  localparam int TO = 40;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       ENABLE = 1'b0;
  logic       BYTE_READY = 1'b0;
  logic [7:0] BYTE_READ = 8'h00;
  logic [1:0] BYTE_ERROR_CODE = 2'b00;
  logic [7:0] X_POS;
  logic [7:0] Y_POS;
  logic [2:0] BUTTONS;
  logic [8:0] DX;
  logic [8:0] DY;
  logic       PACKET_VALID;
  logic       PACKET_ERROR;

  int errors = 0;
  int checks = 0;

  mouse_packet_decoder #(
    .MAX_X   (160),
    .MAX_Y   (120),
    .POS_W   (8),
    .TIMEOUT (TO)
  ) dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .ENABLE          (ENABLE),
    .BYTE_READY      (BYTE_READY),
    .BYTE_READ       (BYTE_READ),
    .BYTE_ERROR_CODE (BYTE_ERROR_CODE),
    .X_POS           (X_POS),
    .Y_POS           (Y_POS),
    .BUTTONS         (BUTTONS),
    .DX              (DX),
    .DY              (DY),
    .PACKET_VALID    (PACKET_VALID),
    .PACKET_ERROR    (PACKET_ERROR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
  endtask

  // Byte is sampled by the posedge following the driving negedge; returns one negedge later.
  task automatic send_byte(input logic [7:0] b, input logic [1:0] err);
    @(negedge CLK);
    BYTE_READY      = 1'b1;
    BYTE_READ       = b;
    BYTE_ERROR_CODE = err;
    @(negedge CLK);
    BYTE_READY      = 1'b0;
    BYTE_READ       = 8'h00;
    BYTE_ERROR_CODE = 2'b00;
  endtask

  task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_byte(b0, 2'b00);
    send_byte(b1, 2'b00);
    send_byte(b2, 2'b00);
  endtask

  task automatic check_pkt(input string tag, input logic [7:0] ex, input logic [7:0] ey,
                           input logic [2:0] eb, input logic [8:0] edx, input logic [8:0] edy);
    chk({tag, ".pv_early"}, 32'(PACKET_VALID), 32'd0);
    chk({tag, ".pe_early"}, 32'(PACKET_ERROR), 32'd0);
    @(negedge CLK);
    chk({tag, ".pv"}, 32'(PACKET_VALID), 32'd1);
    chk({tag, ".pe"}, 32'(PACKET_ERROR), 32'd0);
    chk({tag, ".x"}, 32'(X_POS), 32'(ex));
    chk({tag, ".y"}, 32'(Y_POS), 32'(ey));
    chk({tag, ".btn"}, 32'(BUTTONS), 32'(eb));
    chk({tag, ".dx"}, 32'(DX), 32'(edx));
    chk({tag, ".dy"}, 32'(DY), 32'(edy));
    @(negedge CLK);
    chk({tag, ".pv_drop"}, 32'(PACKET_VALID), 32'd0);
  endtask

  initial begin
    do_reset();
    chk("rst.x", 32'(X_POS), 32'd80);
    chk("rst.y", 32'(Y_POS), 32'd60);
    chk("rst.btn", 32'(BUTTONS), 32'd0);
    chk("rst.dx", 32'(DX), 32'd0);
    chk("rst.dy", 32'(DY), 32'd0);
    chk("rst.pv", 32'(PACKET_VALID), 32'd0);
    chk("rst.pe", 32'(PACKET_ERROR), 32'd0);

    ENABLE = 1'b1;
    send_packet(8'h08, 8'h05, 8'h03);
    check_pkt("basic", 8'd85, 8'd57, 3'b000, 9'h005, 9'h003);

    do_reset();
    send_packet(8'h19, 8'hFB, 8'h00);
    check_pkt("negx", 8'd75, 8'd60, 3'b001, 9'h1FB, 9'h000);

    for (int i = 0; i < 20; i++) begin
      send_packet(8'h08, 8'h7F, 8'h00);
      check_pkt("clampx", 8'd159, 8'd60, 3'b000, 9'h07F, 9'h000);
    end
    for (int i = 0; i < 2; i++) begin
      send_packet(8'h28, 8'h00, 8'h81);
      check_pkt("clampy", 8'd159, 8'd119, 3'b000, 9'h000, 9'h181);
    end

    send_byte(8'h00, 2'b00);
    chk("sync.pe", 32'(PACKET_ERROR), 32'd1);
    chk("sync.pv", 32'(PACKET_VALID), 32'd0);
    @(negedge CLK);
    chk("sync.pe_drop", 32'(PACKET_ERROR), 32'd0);
    send_byte(8'h08, 2'b00);
    chk("b0ok.pe", 32'(PACKET_ERROR), 32'd0);
    send_byte(8'h05, 2'b01);
    chk("parity.pe", 32'(PACKET_ERROR), 32'd1);
    @(negedge CLK);
    chk("parity.pe_drop", 32'(PACKET_ERROR), 32'd0);
    send_packet(8'h18, 8'hF6, 8'h00);
    check_pkt("after_err", 8'd149, 8'd119, 3'b000, 9'h1F6, 9'h000);

    do_reset();
    send_byte(8'h08, 2'b00);
    send_byte(8'h05, 2'b00);
    repeat (TO - 1) @(negedge CLK);
    chk("to.pe_before", 32'(PACKET_ERROR), 32'd0);
    @(negedge CLK);
    chk("to.pe", 32'(PACKET_ERROR), 32'd1);
    @(negedge CLK);
    chk("to.pe_drop", 32'(PACKET_ERROR), 32'd0);
    send_packet(8'h08, 8'h01, 8'h00);
    check_pkt("after_to", 8'd81, 8'd60, 3'b000, 9'h001, 9'h000);

    send_byte(8'h08, 2'b00);
    send_byte(8'h05, 2'b00);
    repeat (TO - 2) @(negedge CLK);
    send_byte(8'h02, 2'b00);
    check_pkt("expiry_byte", 8'd86, 8'd58, 3'b000, 9'h005, 9'h002);

    send_packet(8'h48, 8'h10, 8'h00);
    check_pkt("xovf", 8'd86, 8'd58, 3'b000, 9'h010, 9'h000);

    send_byte(8'h08, 2'b00);
    ENABLE = 1'b0;
    send_byte(8'h05, 2'b00);
    chk("dis.pe1", 32'(PACKET_ERROR), 32'd0);
    chk("dis.pv1", 32'(PACKET_VALID), 32'd0);
    send_byte(8'h03, 2'b00);
    @(negedge CLK);
    chk("dis.pe2", 32'(PACKET_ERROR), 32'd0);
    chk("dis.pv2", 32'(PACKET_VALID), 32'd0);
    chk("dis.x", 32'(X_POS), 32'd86);
    chk("dis.y", 32'(Y_POS), 32'd58);
    ENABLE = 1'b1;
    send_packet(8'h09, 8'h02, 8'h01);
    check_pkt("reenable", 8'd88, 8'd57, 3'b001, 9'h002, 9'h001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
